// File: rtl/irq_ctrl.sv
// irq_ctrl: fixed-priority interrupt controller with EPC/Cause capture and vectoring (IRQ_EDGE_EN selects edge-triggered pending).
module irq_ctrl #(
    parameter int                NUM_IRQ     = 4,
    parameter int                XLEN        = 32,
    parameter logic [XLEN-1:0]   VECTOR_BASE = 32'h0000_0100
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_IRQ-1:0]   irq,
    input  logic [NUM_IRQ-1:0]   irq_mask,
    input  logic                 global_en,
    input  logic                 Stall_F,
    input  logic                 PCSrc_E,
    input  logic [XLEN-1:0]      PCTarget_E,
    input  logic [XLEN-1:0]      PC_D,
    input  logic                 Valid_D,
    input  logic [XLEN-1:0]      PC_F,
    input  logic                 mret_E,
    output logic                 interrupt,
    output logic [XLEN-1:0]      IntVector,
    output logic [XLEN-1:0]      EPC,
    output logic [3:0]           Cause,
    output logic [NUM_IRQ-1:0]   irq_ack,
    output logic                 in_isr
);
    typedef enum logic [1:0] {IDLE, ISR, RET} state_t;
    state_t state, state_nx;
    logic [NUM_IRQ-1:0] pend;
    logic [3:0] sel;
    logic take;
    logic [XLEN-1:0] resume;
`ifdef IRQ_EDGE_EN
    logic [NUM_IRQ-1:0] irq_q, pending;
    // latch rising edges; a fresh edge in the ack cycle beats the clear
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_q   <= '0;
            pending <= '0;
        end else begin
            irq_q   <= irq;
            pending <= (pending & ~irq_ack) | (irq & ~irq_q);
        end
    end
    assign pend = pending & irq_mask;
`else
    assign pend = irq & irq_mask;
`endif
    // lowest set index wins
    always_comb begin
        sel = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--)
            if (pend[i]) sel = 4'(i);
    end
    assign take   = (state == IDLE) & ~rst & (|pend) & global_en & ~Stall_F & ~mret_E;
    assign resume = PCSrc_E ? PCTarget_E : (Valid_D ? PC_D : PC_F);
    // next state and strobes
    always_comb begin
        state_nx  = state;
        if (take) state_nx = ISR;
        else if (state == ISR && mret_E) state_nx = RET;
        else if (state == RET) state_nx = IDLE;
        interrupt = take;
        IntVector = take ? VECTOR_BASE + (XLEN'(sel) << 2) : VECTOR_BASE;
        irq_ack   = take ? NUM_IRQ'(1) << sel : '0;
        in_isr    = (state == ISR);
    end
    // state, resume PC and cause registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            EPC   <= '0;
            Cause <= '0;
        end else begin
            state <= state_nx;
            if (take) begin
                Cause <= sel;
                EPC   <= resume;
            end
        end
    end
endmodule
